// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU function codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_LUI,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_fn_t;

  // Which kind of ALU operation the current state needs.
  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_SUB,
    CLS_R,
    CLS_I
  } alu_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  localparam logic RES_ALUOUT = 1'b0;
  localparam logic RES_MDR    = 1'b1;

endpackage

// File: rtl/alu_op_decode.sv
// Maps the FSM's ALU class plus funct3/funct7_5 onto an ALU function code.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  output alu_fn_t     alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    unique case (alu_class)
      CLS_ADD: alu_op = ALU_ADD;
      CLS_SUB: alu_op = ALU_SUB;
      CLS_R: begin
        // funct7_5=1 is only legal for SUB and SRA; every other combo falls back to ADD
        unique case ({funct7_5, funct3})
          4'b0000: alu_op = ALU_ADD;
          4'b1000: alu_op = ALU_SUB;
          4'b0001: alu_op = ALU_SLL;
          4'b0010: alu_op = ALU_SLT;
          4'b0011: alu_op = ALU_SLTU;
          4'b0100: alu_op = ALU_XOR;
          4'b0101: alu_op = ALU_SRL;
          4'b1101: alu_op = ALU_SRA;
          4'b0110: alu_op = ALU_OR;
          4'b0111: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      CLS_I: begin
        unique case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core, with a retired-instruction
// counter and a sticky illegal-opcode trap.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             alu_cond,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_enable,
  output logic             mem_wr,
  output logic             reg_write,
  output logic             result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_t     state, state_next;
  logic       retire;
  alu_class_t alu_class;
  alu_fn_t    alu_fn;

  alu_op_decode u_alu_op_decode (
    .alu_class (alu_class),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .alu_op    (alu_fn)
  );

  assign alu_op = alu_fn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      retired <= '0;
    end else begin
      state <= state_next;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    alu_class  = CLS_ADD;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    trap       = 1'b0;

    unique case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        mem_enable = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end

      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        unique case (opcode)
          OP_R:               state_next = S_EXEC_R;
          OP_IMM:             state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          OP_JAL:             state_next = S_JAL;
          OP_JALR:            state_next = S_JALR;
          OP_LUI:             state_next = S_LUI;
          default:            state_next = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_class  = CLS_R;
        state_next = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_class  = CLS_I;
        state_next = S_ALU_WB;
      end

      S_LUI: begin
        alu_src_a  = SRC_A_ZERO;
        alu_src_b  = SRC_B_IMM;
        state_next = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        state_next = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        mem_enable = 1'b1;
        iord       = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_MDR;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        iord       = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_class  = CLS_SUB;
        pc_src     = PC_SRC_ALUOUT;
        pc_write   = alu_cond;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      // PC takes the target computed in DECODE while the ALU forms the link value
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_ALUOUT;
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        state_next = S_ALU_WB;
      end

      S_JALR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        pc_write   = 1'b1;
        pc_src     = PC_SRC_ALU;
        state_next = S_LINK;
      end

      S_LINK: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        state_next = S_ALU_WB;
      end

      S_TRAP: trap = 1'b1;

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push
// expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int unsigned CNT_W = 32;

  localparam int T_IDLE = 0,  T_FETCH = 1,  T_DECODE = 2,  T_EXEC_R = 3;
  localparam int T_EXEC_I = 4, T_LUI = 5,   T_ALU_WB = 6,  T_MEM_ADDR = 7;
  localparam int T_MEM_READ = 8, T_MEM_WB = 9, T_MEM_WRITE = 10, T_BRANCH = 11;
  localparam int T_JAL = 12, T_JALR = 13,   T_LINK = 14,   T_TRAP = 15;

  typedef struct packed {
    logic             pc_write;
    logic             pc_src;
    logic             ir_write;
    logic             iord;
    logic             mem_enable;
    logic             mem_wr;
    logic             reg_write;
    logic             result_src;
    logic [1:0]       src_a;
    logic [1:0]       src_b;
    logic [3:0]       op;
    logic             trap;
    logic [CNT_W-1:0] retired;
  } outv_t;

  typedef struct {
    string nm;
    outv_t v;
  } item_t;

  logic             clk = 1'b0;
  logic             rst, alu_cond, mem_ready, funct7_5;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             pc_write, pc_src, ir_write, iord, mem_enable, mem_wr;
  logic             reg_write, result_src, trap;
  logic [1:0]       alu_src_a, alu_src_b;
  logic [3:0]       alu_op;
  logic [CNT_W-1:0] retired;

  item_t       sb_q[$];
  item_t       mon_it;
  outv_t       act;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .alu_cond   (alu_cond),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_enable (mem_enable),
    .mem_wr     (mem_wr),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .trap       (trap),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle, written straight from the state table.
  function automatic outv_t exp_st(int s, logic rdy, logic cond, logic [3:0] aop,
                                   logic [31:0] ret);
    outv_t e;
    e = '0;
    e.retired = ret;
    case (s)
      T_FETCH:     begin e.mem_enable = 1; e.src_b = 2'b10; e.pc_write = rdy; e.ir_write = rdy; end
      T_DECODE:    begin e.src_a = 2'b01; e.src_b = 2'b01; end
      T_EXEC_R:    begin e.src_a = 2'b10; e.src_b = 2'b00; e.op = aop; end
      T_EXEC_I:    begin e.src_a = 2'b10; e.src_b = 2'b01; e.op = aop; end
      T_LUI:       begin e.src_a = 2'b11; e.src_b = 2'b01; end
      T_ALU_WB:    e.reg_write = 1;
      T_MEM_ADDR:  begin e.src_a = 2'b10; e.src_b = 2'b01; end
      T_MEM_READ:  begin e.mem_enable = 1; e.iord = 1; end
      T_MEM_WB:    begin e.reg_write = 1; e.result_src = 1; end
      T_MEM_WRITE: begin e.mem_enable = 1; e.mem_wr = 1; e.iord = 1; end
      T_BRANCH:    begin e.src_a = 2'b10; e.op = 4'd1; e.pc_src = 1; e.pc_write = cond; end
      T_JAL:       begin e.pc_write = 1; e.pc_src = 1; e.src_a = 2'b01; e.src_b = 2'b10; end
      T_JALR:      begin e.src_a = 2'b10; e.src_b = 2'b01; e.pc_write = 1; end
      T_LINK:      begin e.src_a = 2'b01; e.src_b = 2'b10; end
      T_TRAP:      e.trap = 1;
      default:     ;
    endcase
    return e;
  endfunction

  task automatic st(input int s, input logic r, input logic rdy, input logic cond,
                    input logic [3:0] aop, input string nm);
    item_t it;
    rst       = r;
    mem_ready = rdy;
    alu_cond  = cond;
    it.nm     = nm;
    it.v      = exp_st(s, rdy, cond, aop, exp_ret);
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    opcode   = opc;
    funct3   = f3;
    funct7_5 = f7;
  endtask

  task automatic alu_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                           input logic [3:0] aop, input string nm);
    set_ir(opc, f3, f7);
    st(T_FETCH, 0, 1, 0, 4'd0, {nm, "_fetch"});
    st(T_DECODE, 0, 1, 0, 4'd0, {nm, "_decode"});
    st((opc == 7'b0110011) ? T_EXEC_R : T_EXEC_I, 0, 1, 0, aop, {nm, "_exec"});
    st(T_ALU_WB, 0, 1, 0, 4'd0, {nm, "_wb"});
    exp_ret++;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_it = sb_q.pop_front();
      act = {pc_write, pc_src, ir_write, iord, mem_enable, mem_wr, reg_write,
             result_src, alu_src_a, alu_src_b, alu_op, trap, retired};
      checks++;
      if (act !== mon_it.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", mon_it.nm, act, mon_it.v, $time);
      end
    end
  end

  initial begin
    rst = 1; mem_ready = 0; alu_cond = 0;
    set_ir(7'd0, 3'd0, 1'b0);
    @(posedge clk); #1;

    st(T_IDLE, 1, 0, 0, 4'd0, "rst_idle0");
    st(T_IDLE, 0, 0, 0, 4'd0, "rst_idle1");

    alu_instr(7'b0110011, 3'b000, 1'b0, ALU_ADD,  "add");
    alu_instr(7'b0110011, 3'b000, 1'b1, ALU_SUB,  "sub");
    alu_instr(7'b0110011, 3'b001, 1'b1, ALU_ADD,  "r_bad_f7");
    alu_instr(7'b0110011, 3'b011, 1'b0, ALU_SLTU, "sltu");
    alu_instr(7'b0010011, 3'b101, 1'b1, ALU_SRA,  "srai");
    alu_instr(7'b0010011, 3'b001, 1'b1, ALU_SLL,  "slli_f7");
    alu_instr(7'b0010011, 3'b110, 1'b0, ALU_OR,   "ori");

    set_ir(7'b0000011, 3'b010, 1'b0);
    st(T_FETCH, 0, 0, 0, 4'd0, "lw_fetch_w0");
    st(T_FETCH, 0, 0, 0, 4'd0, "lw_fetch_w1");
    st(T_FETCH, 0, 1, 0, 4'd0, "lw_fetch");
    st(T_DECODE, 0, 1, 0, 4'd0, "lw_decode");
    st(T_MEM_ADDR, 0, 1, 0, 4'd0, "lw_addr");
    for (int i = 0; i < 3; i++) st(T_MEM_READ, 0, 0, 0, 4'd0, "lw_read_wait");
    st(T_MEM_READ, 0, 1, 0, 4'd0, "lw_read");
    st(T_MEM_WB, 0, 1, 0, 4'd0, "lw_wb");
    exp_ret++;

    set_ir(7'b0100011, 3'b010, 1'b0);
    st(T_FETCH, 0, 1, 0, 4'd0, "sw_fetch");
    st(T_DECODE, 0, 1, 0, 4'd0, "sw_decode");
    st(T_MEM_ADDR, 0, 1, 0, 4'd0, "sw_addr");
    st(T_MEM_WRITE, 0, 0, 0, 4'd0, "sw_write_wait");
    st(T_MEM_WRITE, 0, 1, 0, 4'd0, "sw_write");
    exp_ret++;

    set_ir(7'b1100011, 3'b000, 1'b0);
    st(T_FETCH, 0, 1, 1, 4'd0, "beq_t_fetch");
    st(T_DECODE, 0, 1, 1, 4'd0, "beq_t_decode");
    st(T_BRANCH, 0, 1, 1, 4'd0, "beq_t_branch");
    exp_ret++;
    st(T_FETCH, 0, 1, 0, 4'd0, "beq_n_fetch");
    st(T_DECODE, 0, 1, 0, 4'd0, "beq_n_decode");
    st(T_BRANCH, 0, 1, 0, 4'd0, "beq_n_branch");
    exp_ret++;

    set_ir(7'b1101111, 3'b000, 1'b0);
    st(T_FETCH, 0, 1, 0, 4'd0, "jal_fetch");
    st(T_DECODE, 0, 1, 0, 4'd0, "jal_decode");
    st(T_JAL, 0, 1, 0, 4'd0, "jal_jump");
    st(T_ALU_WB, 0, 1, 0, 4'd0, "jal_wb");
    exp_ret++;

    set_ir(7'b1100111, 3'b000, 1'b0);
    st(T_FETCH, 0, 1, 0, 4'd0, "jalr_fetch");
    st(T_DECODE, 0, 1, 0, 4'd0, "jalr_decode");
    st(T_JALR, 0, 1, 0, 4'd0, "jalr_jump");
    st(T_LINK, 0, 1, 0, 4'd0, "jalr_link");
    st(T_ALU_WB, 0, 1, 0, 4'd0, "jalr_wb");
    exp_ret++;

    set_ir(7'b0110111, 3'b000, 1'b0);
    st(T_FETCH, 0, 1, 0, 4'd0, "lui_fetch");
    st(T_DECODE, 0, 1, 0, 4'd0, "lui_decode");
    st(T_LUI, 0, 1, 0, 4'd0, "lui_exec");
    st(T_ALU_WB, 0, 1, 0, 4'd0, "lui_wb");
    exp_ret++;

    set_ir(7'b1111111, 3'b000, 1'b0);
    st(T_FETCH, 0, 1, 0, 4'd0, "ill_fetch");
    st(T_DECODE, 0, 1, 0, 4'd0, "ill_decode");
    for (int i = 0; i < 20; i++) st(T_TRAP, 0, (i % 2) == 0, 1, 4'd0, "trap_hold");
    st(T_TRAP, 1, 1, 0, 4'd0, "trap_rst");
    exp_ret = 0;
    st(T_IDLE, 0, 1, 0, 4'd0, "trap_idle");

    set_ir(7'b0100011, 3'b010, 1'b0);
    st(T_FETCH, 0, 1, 0, 4'd0, "sw2_fetch");
    st(T_DECODE, 0, 1, 0, 4'd0, "sw2_decode");
    st(T_MEM_ADDR, 0, 1, 0, 4'd0, "sw2_addr");
    st(T_MEM_WRITE, 0, 0, 0, 4'd0, "sw2_write_wait");
    st(T_MEM_WRITE, 1, 0, 0, 4'd0, "sw2_write_rst");
    exp_ret = 0;
    st(T_IDLE, 0, 0, 0, 4'd0, "sw2_idle");
    st(T_FETCH, 0, 0, 0, 4'd0, "restart_fetch");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core. It sequences one shared memory, the ALU, the register file and the PC/IR/ALUOut/MDR holding registers over several cycles per instruction.
- A memory handshake (mem_ready) stretches the memory states.
- The block also keeps a retired-instruction counter.
- It raises a sticky trap on any unsupported opcode.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- alu_cond  in  1  ALU branch-condition result for the current funct3 (1 = taken)
- mem_ready  in  1  shared memory has completed the current access
- pc_write  out  1  load PC
- pc_src  out  1  0 = ALU result, 1 = ALUOut register
- ir_write  out  1  load IR and OldPC
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_enable  out  1  memory access strobe
- mem_wr  out  1  memory write
- reg_write  out  1  register-file write enable
- result_src  out  1  rf data_in: 0 = ALUOut, 1 = MDR
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- alu_op  out  4  ALU function code (ctrl_pkg)
- trap  out  1  illegal-opcode halt, sticky
- retired  out  CNT_W  instructions completed since reset

Behaviour:
- Outputs are Moore, decoded from the state register. The only exceptions are the FETCH and MEM_WRITE strobes, which are gated by mem_ready as noted below.
- Reset (rst high at a clk edge, at any time including mid-instruction):
  - state goes to IDLE and retired goes to 0.
  - In IDLE every output is 0.
  - IDLE goes to FETCH on the next edge unconditionally.
  - Any in-flight memory access is abandoned.
- FETCH:
  - Asserted: mem_enable=1, iord=0, alu_src_a=00, alu_src_b=10, alu_op=ADD, pc_src=0.
  - Each cycle with mem_ready=1: ir_write=1 and pc_write=1 in that cycle, next state DECODE.
  - Otherwise hold in FETCH with both strobes low.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=ADD, so ALUOut = branch/JAL target. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - anything else → TRAP
- EXEC_R: src_a=10, src_b=00, alu_op decoded from {funct7_5, funct3} → ALU_WB.
- EXEC_I: src_a=10, src_b=01, alu_op decoded from funct3. funct7_5 is used only for funct3=101 (SRLI/SRAI). → ALU_WB.
- LUI: src_a=11, src_b=01, ADD → ALU_WB.
- ALU_WB: reg_write=1, result_src=0, retired+1 → FETCH.
- MEM_ADDR: src_a=10, src_b=01, ADD. Next is MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: mem_enable=1, iord=1. Wait while mem_ready=0; on mem_ready=1 → MEM_WB.
- MEM_WB: reg_write=1, result_src=1, retired+1 → FETCH.
- MEM_WRITE: mem_enable=1, mem_wr=1, iord=1. Wait while mem_ready=0; on mem_ready=1 → FETCH with retired+1.
- BRANCH:
  - Asserted: src_a=10, src_b=00, alu_op=SUB, pc_src=1.
  - pc_write = alu_cond.
  - retired+1 → FETCH.
- JAL: pc_write=1, pc_src=1, src_a=01, src_b=10, ADD (ALUOut gets OldPC+4) → ALU_WB.
- JALR:
  - Asserted: src_a=10, src_b=01, ADD, pc_write=1, pc_src=0.
  - The datapath clears the target LSB.
  - → LINK.
- LINK: src_a=01, src_b=10, ADD → ALU_WB.
- TRAP: trap=1, all other strobes 0. Held until rst.
- Cycle counts with zero-wait memory:
  - R/I/LUI: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
  - Each mem_ready=0 cycle adds one cycle.
- Arithmetic: retired wraps modulo 2^CNT_W with no saturation. An increment and rst in the same cycle give 0.
- alu_op for R/I decode: unsupported funct3/funct7_5 combinations in EXEC_R/EXEC_I map to ADD. They do not trap.

Decomposition:
- ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC_R, EXEC_I, LUI, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JAL, JALR, LINK, TRAP)
  - opcode constants
  - ALU function codes (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU)
  - alu_src_a/b and pc_src/result_src select encodings
- One sub-module, alu_op_decode: combinational mapping of {state class, funct3, funct7_5} to alu_op.
- The FSM and the counter stay in multicycle_ctrl.

Test Plan:
- Hold rst 2 cycles, then release → outputs all 0 in IDLE; mem_enable=1 one cycle later; retired=0.
- add x3,x1,x2 (opcode 0110011, funct3 000, funct7_5 0), mem_ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB; alu_op=ADD in EXEC_R; reg_write high exactly 1 cycle; retired=1 after 4 cycles.
- lw (0000011), mem_ready low 2 cycles in FETCH and 3 cycles in MEM_READ → total 10 cycles; ir_write and pc_write high only in the mem_ready cycle; result_src=1 at MEM_WB.
- beq (1100011), alu_cond=1, then repeat with alu_cond=0 → pc_write=1 with pc_src=1 in BRANCH, then pc_write=0; both take 3 cycles; retired +1 each.
- Opcode 1111111 → TRAP after DECODE; trap=1 and no strobes for 20 cycles; rst clears trap and restarts FETCH.
- rst asserted during MEM_WRITE with mem_ready=0 → next cycle IDLE; mem_wr=0; retired=0.
